ube_pwrfail_seq: RTL and testbench
==================================

Name: ube_pwrfail_seq

Overview:
- Unibus Exerciser power-fail sequencer.
- Turns the level-sensitive ACLO control bit from UBE CSR2 into a timed Unibus power-fail/power-up sequence: ACLO warning, DCLO, INIT, recovery.
- Sits between the CSR2 register and the UBE Unibus line drivers, so diagnostics can exercise power-fail/restart handling.
- Also produces interrupt pulses and a phase code for CSR readback.

Parameters:
- T_WARN, 250000: cycles ACLO is asserted alone before DCLO asserts (5 ms at 50 MHz).
- T_DCLO_MIN, 100: minimum cycles DCLO stays asserted.
- T_INIT, 50: cycles INIT stays asserted after DCLO negates.
- T_UP, 250000: cycles ACLO stays asserted after INIT negates.
- CNTW, 20: timer width; must satisfy 2**CNTW > every T_* value. Every T_* value is at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- devRESET  in  1  device reset (Unibus INIT from host); same effect as rst
- csr2ACLO  in  1  CSR2 bit 4 level
- ubeACLO  out  1  Unibus ACLO drive
- ubeDCLO  out  1  Unibus DCLO drive
- ubeINIT  out  1  Unibus INIT drive
- pfINTR  out  1  one-cycle pulse: power-fail warning started
- puINTR  out  1  one-cycle pulse: power-up sequence complete
- busy  out  1  state != IDLE
- phase  out  3  state encoding: IDLE=0, WARN=1, DOWN=2, INITP=3, UP=4

Behaviour:
- Timing: all outputs are registered; each is a function of the current state, except pfINTR/puINTR, which are registered pulses.
- Reset: rst or devRESET forces state IDLE, timer 0, prevACLO 0, and all outputs 0 on the same edge, from any state (abort mid-sequence, no puINTR).
- Edge detect: prevACLO <= csr2ACLO every cycle. rise = csr2ACLO & ~prevACLO.
  - If csr2ACLO is already 1 when reset releases, the sequence starts on the first non-reset edge.
- Timer: on entry to a timed state with duration N, load N-1; decrement each cycle; "expired" = timer==0.
- Outputs per state:
  - IDLE: ACLO=0, DCLO=0, INIT=0.
  - WARN: ACLO=1.
  - DOWN: ACLO=1, DCLO=1, INIT=1.
  - INITP: ACLO=1, INIT=1.
  - UP: ACLO=1.
- IDLE: on rise -> WARN, load T_WARN, pfINTR=1 for exactly the cycle ACLO first asserts. A rise seen in any other state is ignored.
- WARN: lasts exactly T_WARN cycles if csr2ACLO stays 1.
  - If csr2ACLO==0 is sampled before expiry -> IDLE (glitch abort: ACLO drops, DCLO never asserts, no puINTR).
  - On expiry with csr2ACLO==1 -> DOWN, load T_DCLO_MIN.
  - Abort takes priority over expiry in the same cycle.
- DOWN: stays until expired AND csr2ACLO==0, then -> INITP, load T_INIT. The timer holds at 0 after expiry while csr2ACLO remains 1.
- INITP: lasts exactly T_INIT cycles -> UP, load T_UP. csr2ACLO is ignored.
- UP: lasts exactly T_UP cycles -> IDLE, with puINTR=1 on the first IDLE cycle.
  - A csr2ACLO rise during INITP/UP does not restart the sequence. If csr2ACLO is still 1 once in IDLE, no new start occurs until csr2ACLO falls and rises again.
- Ordering guarantees:
  - DCLO asserts only after ACLO has been asserted T_WARN cycles.
  - ACLO negates only after DCLO has been negated for T_INIT+T_UP cycles.
  - INIT never asserts without DCLO asserting first.
- pfINTR and puINTR are never both 1. Each is high for exactly one cycle per event.

Test Plan:
1. Params T_WARN=4, T_DCLO_MIN=3, T_INIT=2, T_UP=2. After reset, raise csr2ACLO at edge k.
   - ACLO=1 and pfINTR=1 after edge k; pfINTR=0 after edge k+1.
   - DCLO=INIT=1 after edge k+4.
   - Drop csr2ACLO at edge k+10: DCLO=0 after k+11, INIT=0 after k+13, ACLO=0 and puINTR=1 after k+15.
2. Glitch: raise csr2ACLO, drop it after 2 cycles in WARN -> ACLO=0 after 3 cycles total; DCLO and INIT never assert; puINTR never pulses; phase returns to 0.
3. Minimum DCLO: pulse csr2ACLO high only until DCLO asserts, then low -> DCLO stays high exactly T_DCLO_MIN=3 cycles before INITP.
4. Reset mid-operation: assert devRESET while in DOWN -> next edge all outputs 0, phase=0, busy=0, no puINTR. With csr2ACLO held 1 and devRESET released, a new sequence starts with pfINTR on the next edge.
5. Re-trigger: toggle csr2ACLO 0->1 during INITP and UP -> sequence timing unchanged, with a single puINTR. Held 1 into IDLE -> no restart; a later 0->1 restarts with pfINTR.
6. Phase/busy tracking through scenario 1: phase sequence 0,1,2,3,4,0; busy=1 exactly while phase!=0.

Source files
------------

// File: rtl/ube_pwrfail_seq.sv
// Unibus Exerciser power-fail sequencer.
// Turns the CSR2 ACLO level into a timed ACLO -> DCLO -> INIT -> recovery
// sequence on the Unibus drivers, with interrupt pulses and a phase code.
module ube_pwrfail_seq #(
  parameter int unsigned T_WARN     = 250000,
  parameter int unsigned T_DCLO_MIN = 100,
  parameter int unsigned T_INIT     = 50,
  parameter int unsigned T_UP       = 250000,
  parameter int unsigned CNTW       = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       devRESET,
  input  logic       csr2ACLO,
  output logic       ubeACLO,
  output logic       ubeDCLO,
  output logic       ubeINIT,
  output logic       pfINTR,
  output logic       puINTR,
  output logic       busy,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWarn  = 3'd1,
    StDown  = 3'd2,
    StInitp = 3'd3,
    StUp    = 3'd4
  } state_e;

  // Timer loads are duration-1 so that "expired" (timer==0) lands on the last cycle.
  localparam logic [CNTW-1:0] LdWarn = CNTW'(T_WARN - 1);
  localparam logic [CNTW-1:0] LdDclo = CNTW'(T_DCLO_MIN - 1);
  localparam logic [CNTW-1:0] LdInit = CNTW'(T_INIT - 1);
  localparam logic [CNTW-1:0] LdUp   = CNTW'(T_UP - 1);

  state_e            stateQ, stateD;
  logic [CNTW-1:0]   timerQ, timerD;
  logic              prevACLO;
  logic              pfD, puD;
  logic              rise, expired;

  assign rise    = csr2ACLO & ~prevACLO;
  assign expired = (timerQ == '0);

  // Next-state, timer and interrupt-pulse decode.
  always_comb begin
    stateD = stateQ;
    timerD = expired ? timerQ : timerQ - 1'b1;
    pfD    = 1'b0;
    puD    = 1'b0;
    unique case (stateQ)
      StIdle: begin
        timerD = '0;
        if (rise) begin
          stateD = StWarn;
          timerD = LdWarn;
          pfD    = 1'b1;
        end
      end
      StWarn: begin
        // A dropped request aborts even on the expiry cycle.
        if (!csr2ACLO) begin
          stateD = StIdle;
          timerD = '0;
        end else if (expired) begin
          stateD = StDown;
          timerD = LdDclo;
        end
      end
      StDown: begin
        // Timer parks at zero while the request is still held.
        if (expired && !csr2ACLO) begin
          stateD = StInitp;
          timerD = LdInit;
        end
      end
      StInitp: begin
        if (expired) begin
          stateD = StUp;
          timerD = LdUp;
        end
      end
      StUp: begin
        if (expired) begin
          stateD = StIdle;
          timerD = '0;
          puD    = 1'b1;
        end
      end
      default: begin
        stateD = StIdle;
        timerD = '0;
      end
    endcase
  end

  // State, timer, edge history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst || devRESET) begin
      stateQ   <= StIdle;
      timerQ   <= '0;
      prevACLO <= 1'b0;
      ubeACLO  <= 1'b0;
      ubeDCLO  <= 1'b0;
      ubeINIT  <= 1'b0;
      pfINTR   <= 1'b0;
      puINTR   <= 1'b0;
      busy     <= 1'b0;
      phase    <= 3'd0;
    end else begin
      stateQ   <= stateD;
      timerQ   <= timerD;
      prevACLO <= csr2ACLO;
      ubeACLO  <= (stateD != StIdle);
      ubeDCLO  <= (stateD == StDown);
      ubeINIT  <= (stateD == StDown) || (stateD == StInitp);
      pfINTR   <= pfD;
      puINTR   <= puD;
      busy     <= (stateD != StIdle);
      phase    <= 3'(stateD);
    end
  end

endmodule

// File: tb/tb_ube_pwrfail_seq.sv
// Self-checking bench for ube_pwrfail_seq: scenario table, hand-written
// corner sequences and random stimulus against a stage/age reference model.
module tb_ube_pwrfail_seq;

  localparam int unsigned TW = 4, TD = 3, TI = 2, TU = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1, devRESET = 1'b0, csr2ACLO = 1'b0;
  logic       ubeACLO, ubeDCLO, ubeINIT, pfINTR, puINTR, busy;
  logic [2:0] phase;

  int errors = 0, checks = 0;
  int puCount = 0, dcloSeen = 0;

  // Reference model: stage index, cycles spent in stage, last request level.
  int mStg = 0, mAge = 0;
  bit mPrev = 0, mPf = 0, mPu = 0;

  typedef struct {
    logic       r;
    logic       a;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[18];

  ube_pwrfail_seq #(
    .T_WARN(TW), .T_DCLO_MIN(TD), .T_INIT(TI), .T_UP(TU), .CNTW(8)
  ) dut (
    .clk(clk), .rst(rst), .devRESET(devRESET), .csr2ACLO(csr2ACLO),
    .ubeACLO(ubeACLO), .ubeDCLO(ubeDCLO), .ubeINIT(ubeINIT),
    .pfINTR(pfINTR), .puINTR(puINTR), .busy(busy), .phase(phase)
  );

  always #5 clk = ~clk;

  function automatic int durOf(int s);
    case (s)
      1: return TW;
      2: return TD;
      3: return TI;
      4: return TU;
      default: return 1;
    endcase
  endfunction

  function automatic void modelStep(bit r, bit a);
    int nxt;
    bit done;
    mPf = 0;
    mPu = 0;
    if (r) begin
      mStg = 0; mAge = 0; mPrev = 0;
    end else begin
      nxt  = mStg;
      done = (mAge + 1 >= durOf(mStg));
      case (mStg)
        0: if (a && !mPrev) begin nxt = 1; mPf = 1; end
        1: if (!a) nxt = 0; else if (done) nxt = 2;
        2: if (done && !a) nxt = 3;
        3: if (done) nxt = 4;
        4: if (done) begin nxt = 0; mPu = 1; end
        default: nxt = 0;
      endcase
      if (nxt != mStg) mAge = 0;
      else mAge++;
      mStg  = nxt;
      mPrev = a;
    end
  endfunction

  function automatic logic [8:0] modelOut();
    logic [2:0] p;
    p = 3'(mStg);
    return {mStg != 0, mStg == 2, (mStg == 2) || (mStg == 3), mPf, mPu, mStg != 0, p};
  endfunction

  function automatic logic [8:0] dutOut();
    return {ubeACLO, ubeDCLO, ubeINIT, pfINTR, puINTR, busy, phase};
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got aclo/dclo/init/pf/pu/busy/phase=%b, expected %b", name, got, exp);
    end
  endtask

  // One clock: drive inputs, advance model with the sampled values, compare after the edge.
  task automatic cyc(input logic r, input logic d, input logic a, input string name);
    rst = r; devRESET = d; csr2ACLO = a;
    @(posedge clk);
    modelStep(r || d, a);
    #1;
    if (puINTR === 1'b1) puCount++;
    if (ubeDCLO === 1'b1) dcloSeen++;
    check(name, dutOut(), modelOut());
  endtask

  task automatic countCheck(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int n;
    bit a;
    // Scenario 1 and phase/busy tracking: rows are {rst, csr2ACLO, expected outputs}.
    tbl[0] = '{1'b1, 1'b0, 9'b0_0_0_0_0_0_000};
    tbl[1] = '{1'b0, 1'b1, 9'b1_0_0_1_0_1_001};
    for (int i = 2; i <= 4; i++) tbl[i] = '{1'b0, 1'b1, 9'b1_0_0_0_0_1_001};
    for (int i = 5; i <= 11; i++) tbl[i] = '{1'b0, 1'b1, 9'b1_1_1_0_0_1_010};
    for (int i = 12; i <= 13; i++) tbl[i] = '{1'b0, 1'b0, 9'b1_0_1_0_0_1_011};
    for (int i = 14; i <= 15; i++) tbl[i] = '{1'b0, 1'b0, 9'b1_0_0_0_0_1_100};
    tbl[16] = '{1'b0, 1'b0, 9'b0_0_0_0_1_0_000};
    tbl[17] = '{1'b0, 1'b0, 9'b0_0_0_0_0_0_000};
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].r, 1'b0, tbl[i].a, $sformatf("seq_row%0d_model", i));
      check($sformatf("seq_row%0d", i), dutOut(), tbl[i].exp);
    end

    // Glitch abort in WARN.
    cyc(1, 0, 0, "glitch_rst");
    dcloSeen = 0; puCount = 0;
    cyc(0, 0, 1, "glitch_w0");
    cyc(0, 0, 1, "glitch_w1");
    cyc(0, 0, 0, "glitch_abort");
    check("glitch_idle", dutOut(), 9'b0);
    cyc(0, 0, 0, "glitch_after");
    countCheck("glitch_no_dclo", dcloSeen, 0);
    countCheck("glitch_no_pu", puCount, 0);

    // Minimum DCLO width.
    cyc(1, 0, 0, "mindclo_rst");
    n = 0;
    while (ubeDCLO !== 1'b1 && n < 20) begin cyc(0, 0, 1, "mindclo_up"); n++; end
    countCheck("mindclo_reached", int'(ubeDCLO === 1'b1), 1);
    n = 1;
    for (int i = 0; i < 20 && ubeDCLO === 1'b1; i++) begin
      cyc(0, 0, 0, "mindclo_hold");
      if (ubeDCLO === 1'b1) n++;
    end
    countCheck("mindclo_width", n, TD);
    check("mindclo_initp", dutOut(), 9'b1_0_1_0_0_1_011);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, "mindclo_tail");

    // devRESET mid-sequence, then restart with request held.
    cyc(1, 0, 0, "devrst_rst");
    puCount = 0;
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, "devrst_run");
    check("devrst_in_down", dutOut(), 9'b1_1_1_0_0_1_010);
    cyc(0, 1, 1, "devrst_hit");
    check("devrst_clear", dutOut(), 9'b0);
    cyc(0, 0, 1, "devrst_restart");
    check("devrst_pf", dutOut(), 9'b1_0_0_1_0_1_001);
    countCheck("devrst_no_pu", puCount, 0);

    // Re-trigger during INITP/UP, held into IDLE, then fresh rise.
    cyc(1, 0, 0, "retrig_rst");
    puCount = 0;
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, "retrig_run");
    n = 0;
    while (phase !== 3'd3 && n < 20) begin cyc(0, 0, 0, "retrig_fall"); n++; end
    cyc(0, 0, 1, "retrig_initp_rise");
    cyc(0, 0, 0, "retrig_to_up");
    cyc(0, 0, 1, "retrig_up_rise");
    cyc(0, 0, 1, "retrig_to_idle");
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, "retrig_held");
    check("retrig_no_restart", dutOut(), 9'b0);
    countCheck("retrig_single_pu", puCount, 1);
    cyc(0, 0, 0, "retrig_low");
    cyc(0, 0, 1, "retrig_rise");
    check("retrig_pf", dutOut(), 9'b1_0_0_1_0_1_001);

    // Random runs of held request levels with occasional resets.
    n = 0;
    a = 0;
    for (int i = 0; i < 3000; i++) begin
      if (n == 0) begin
        a = bit'($urandom_range(0, 1));
        n = $urandom_range(1, 9);
      end
      n--;
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 149) == 0), a, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
